// File: rtl/calc_pkg.sv
// Shared definitions for the nexys3 calculator: instruction word layout,
// opcodes and the capture-stage FSM state type.
package calc_pkg;

  localparam int unsigned INST_W = 8;

  // Opcodes carried in the top two bits of an instruction word
  localparam logic [1:0] PUSH = 2'b00;
  localparam logic [1:0] ADD  = 2'b01;
  localparam logic [1:0] MULT = 2'b10;
  localparam logic [1:0] SEND = 2'b11;

  // Field positions inside inst_wd: {op[1:0], ra[1:0], imm/rb/rc[3:0]}
  localparam int unsigned OP_MSB  = 7;
  localparam int unsigned OP_LSB  = 6;
  localparam int unsigned RA_MSB  = 5;
  localparam int unsigned RA_LSB  = 4;
  localparam int unsigned ARG_MSB = 3;
  localparam int unsigned ARG_LSB = 0;

  typedef struct packed {
    logic [1:0] op;
    logic [1:0] ra;
    logic [3:0] arg;
  } inst_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_VALID = 1'b1
  } cap_state_t;

  // Opcode field of a raw instruction word
  function automatic logic [1:0] inst_op(input logic [INST_W-1:0] wd);
    return wd[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/inst_capture_debounce.sv
// Button conditioner: 2-flop synchroniser followed by a stability counter.
// btn_db only changes after the synchronised input has differed from it for
// DB_CYCLES consecutive cycles; any return to the btn_db level restarts the count.
module debounce #(
  parameter int unsigned DB_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic btn_db
);

  localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             btn_sync;
  logic             mismatch_c;
  logic [CNT_W-1:0] cnt;

  assign btn_sync   = sync_q[1];
  assign mismatch_c = btn_sync ^ btn_db;

  // Two-stage synchroniser for the asynchronous button input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], btn};
    end
  end

  // Stability counter; toggles btn_db once the new level has held long enough
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      btn_db <= 1'b0;
    end else if (!mismatch_c) begin
      cnt    <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt    <= '0;
      btn_db <= ~btn_db;
    end else begin
      cnt    <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/inst_capture.sv
// Instruction capture front end: debounces btnS, samples sw on each press and
// offers it to the executor over a valid/ready handshake with one-deep storage.
// Presses arriving while a word is still pending are counted in drop_cnt.
// Optional feature macro: INST_CAPTURE_REPEAT_EN adds auto-repeat while the
// button is held (one extra press every REPEAT_CYCLES cycles).
module inst_capture
  import calc_pkg::*;
#(
  parameter int unsigned DB_CYCLES     = 250000,
  parameter int unsigned REPEAT_CYCLES = 50000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btnS,
  input  logic [INST_W-1:0] sw,
  input  logic              inst_rdy,
  output logic              inst_vld,
  output logic [INST_W-1:0] inst_wd,
  output logic              btn_db,
  output logic [7:0]        drop_cnt
);

  // Reject degenerate timing parameters at elaboration
  if (DB_CYCLES == 0) begin : g_bad_db
    $error("inst_capture: DB_CYCLES must be nonzero");
  end
  if (REPEAT_CYCLES == 0) begin : g_bad_repeat
    $error("inst_capture: REPEAT_CYCLES must be nonzero");
  end

  cap_state_t        state, state_n;
  logic [INST_W-1:0] sw_meta, sw_sync;
  logic              btn_db_q;
  logic              press_db_c;
  logic              press_c;
  logic              accept_c;
  logic              load_c;
  logic              drop_c;

  debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn    (btnS),
    .btn_db (btn_db)
  );

  // Two-stage synchroniser for the instruction switches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
    end
  end

  // Delayed btn_db for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_db_q <= 1'b0;
    end else begin
      btn_db_q <= btn_db;
    end
  end

  assign press_db_c = btn_db & ~btn_db_q;

`ifdef INST_CAPTURE_REPEAT_EN
  localparam int unsigned REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_CYCLES - 1);

  logic [REP_W-1:0] rep_cnt;
  logic             held_c;
  logic             rep_hit_c;

  // Held means past the original press cycle; phase is measured from that press
  assign held_c    = btn_db & btn_db_q;
  assign rep_hit_c = held_c & (rep_cnt == REP_MAX);

  // Auto-repeat period counter, idle whenever the button is not held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt <= '0;
    end else if (!held_c || rep_hit_c) begin
      rep_cnt <= '0;
    end else begin
      rep_cnt <= rep_cnt + REP_W'(1);
    end
  end

  assign press_c = press_db_c | rep_hit_c;
`else
  assign press_c = press_db_c;
`endif

  assign accept_c = inst_vld & inst_rdy;

  // Handshake state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state plus load/drop decisions
  always_comb begin
    state_n = state;
    load_c  = 1'b0;
    drop_c  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (press_c) begin
          load_c  = 1'b1;
          state_n = ST_VALID;
        end
      end
      ST_VALID: begin
        if (accept_c) begin
          if (press_c) begin
            load_c  = 1'b1;
          end else begin
            state_n = ST_IDLE;
          end
        end else if (press_c) begin
          drop_c = 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Registered handshake outputs; the word holds its value while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_vld <= 1'b0;
      inst_wd  <= '0;
    end else begin
      inst_vld <= (state_n == ST_VALID);
      if (load_c) begin
        inst_wd <= sw_sync;
      end
    end
  end

  // Saturating count of presses lost to backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (drop_c && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_inst_capture.sv
// Bench for inst_capture: stimulus pushes expected words (and, where the
// timing is fixed, the cycle of their acceptance); a monitor pops on every accept.
module tb_inst_capture;

  localparam int unsigned DB = 16;
  localparam int unsigned RP = 100;

  logic       clk;
  logic       rst_n;
  logic       btnS;
  logic [7:0] sw;
  logic       inst_rdy;
  logic       inst_vld;
  logic [7:0] inst_wd;
  logic       btn_db;
  logic [7:0] drop_cnt;

  inst_capture #(
    .DB_CYCLES     (DB),
    .REPEAT_CYCLES (RP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btnS     (btnS),
    .sw       (sw),
    .inst_rdy (inst_rdy),
    .inst_vld (inst_vld),
    .inst_wd  (inst_wd),
    .btn_db   (btn_db),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] wd;
    int         at;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic at_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic expect_wd(input logic [7:0] wd, input int at);
    exp_t e;
    e.wd = wd;
    e.at = at;
    exp_q.push_back(e);
  endtask

  task automatic press(input logic [7:0] wd, input int hold, input int gap);
    sw   = wd;
    btnS = 1'b1;
    tick(hold);
    btnS = 1'b0;
    tick(gap);
  endtask

  // Monitor: every accepted word must match the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && inst_vld && inst_rdy) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL accept_unexpected: got word 0x%0h at cycle %0d, want none", inst_wd, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("accept_wd", int'(inst_wd), int'(e.wd));
          if (e.at >= 0) chk("accept_cycle", cyc, e.at);
        end
      end
    end
  end

  int t0;

  initial begin
    rst_n    = 1'b0;
    btnS     = 1'b0;
    sw       = 8'h00;
    inst_rdy = 1'b0;
    tick(3);
    chk("reset_vld", int'(inst_vld), 0);
    chk("reset_wd", int'(inst_wd), 0);
    chk("reset_btn_db", int'(btn_db), 0);
    chk("reset_drop", int'(drop_cnt), 0);
    rst_n = 1'b1;
    tick(3);

    // Clean press with the executor always ready
    inst_rdy = 1'b1;
    sw       = 8'h04;
    btnS     = 1'b1;
    t0       = cyc;
    expect_wd(8'h04, t0 + 19);
    at_cyc(t0 + 17);
    chk("clean_btn_db_early", int'(btn_db), 0);
    at_cyc(t0 + 18);
    chk("clean_btn_db_rise", int'(btn_db), 1);
    tick(22);
    btnS = 1'b0;
    tick(40);

    // Bouncy press: 5-cycle toggles never survive the debounce window
    sw = 8'h41;
    for (int i = 0; i < 12; i++) begin
      btnS = (i % 2 == 0);
      tick(5);
    end
    chk("bounce_btn_db_quiet", int'(btn_db), 0);
    btnS = 1'b1;
    t0   = cyc;
    expect_wd(8'h41, t0 + 19);
    at_cyc(t0 + 17);
    chk("bounce_btn_db_early", int'(btn_db), 0);
    at_cyc(t0 + 18);
    chk("bounce_btn_db_rise", int'(btn_db), 1);
    tick(12);
    btnS = 1'b0;
    tick(40);

    // Backpressure: second press is dropped, first word held
    inst_rdy = 1'b0;
    expect_wd(8'h24, -1);
    press(8'h24, 25, 30);
    press(8'h13, 25, 30);
    chk("bp_vld_held", int'(inst_vld), 1);
    chk("bp_wd_held", int'(inst_wd), 8'h24);
    chk("bp_drop", int'(drop_cnt), 1);
    inst_rdy = 1'b1;
    t0       = cyc;
    at_cyc(t0 + 1);
    chk("bp_vld_fall", int'(inst_vld), 0);
    tick(1);
    inst_rdy = 1'b0;
    tick(5);

    // Accept and new press on the same edge: no bubble, no drop
    expect_wd(8'h55, -1);
    press(8'h55, 25, 30);
    chk("sim_vld_first", int'(inst_vld), 1);
    chk("sim_wd_first", int'(inst_wd), 8'h55);
    sw   = 8'h66;
    btnS = 1'b1;
    t0   = cyc;
    expect_wd(8'h66, t0 + 19);
    tick(18);
    inst_rdy = 1'b1;
    tick(1);
    chk("sim_vld_kept", int'(inst_vld), 1);
    chk("sim_drop", int'(drop_cnt), 1);
    tick(10);
    btnS = 1'b0;
    tick(30);

    // Build up drop_cnt=3 while VALID, then reset asynchronously
    inst_rdy = 1'b0;
    press(8'h77, 25, 30);
    press(8'h78, 25, 30);
    press(8'h79, 25, 30);
    chk("rst_pre_drop", int'(drop_cnt), 3);
    chk("rst_pre_vld", int'(inst_vld), 1);
    sw   = 8'h9A;
    btnS = 1'b1;
    tick(6);
    rst_n = 1'b0;
    #1;
    chk("rst_async_vld", int'(inst_vld), 0);
    chk("rst_async_wd", int'(inst_wd), 0);
    chk("rst_async_btn_db", int'(btn_db), 0);
    chk("rst_async_drop", int'(drop_cnt), 0);
    tick(3);
    rst_n    = 1'b1;
    inst_rdy = 1'b1;
    t0       = cyc;
    expect_wd(8'h9A, t0 + 19);
    tick(40);
    btnS = 1'b0;
    tick(40);

    // Long hold: auto-repeat only when the feature is built in
    sw   = 8'hC3;
    btnS = 1'b1;
    t0   = cyc;
    expect_wd(8'hC3, t0 + 19);
`ifdef INST_CAPTURE_REPEAT_EN
    expect_wd(8'hC3, t0 + 119);
    expect_wd(8'hC4, t0 + 219);
    expect_wd(8'hC4, t0 + 319);
`endif
    tick(150);
    sw = 8'hC4;
    tick(200);
    btnS = 1'b0;
    tick(40);
    chk("final_drop", int'(drop_cnt), 0);
    chk("final_pending", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
